// File: rtl/midi_mono_decoder_if.sv
// ---------------------------------------------------------------------------
// midi_mono_decoder_if
//   Byte-stream bus carrying raw MIDI bytes into midi_mono_decoder.
//   midi_byte   8  received MIDI byte
//   midi_valid  1  one-cycle strobe, midi_byte valid this cycle
//   Modports: master (byte source), slave (decoder side).
// ---------------------------------------------------------------------------
interface midi_mono_decoder_if;
    logic [7:0] midi_byte;
    logic       midi_valid;

    modport master (output midi_byte, output midi_valid);
    modport slave  (input  midi_byte, input  midi_valid);
endinterface

// File: rtl/midi_mono_decoder.sv
// ---------------------------------------------------------------------------
// midi_mono_decoder
//   Parses raw MIDI bytes for one selected channel into a monophonic voice
//   state (gate, note, 4-bit velocity, 9-bit pitch bend) with last-note
//   priority, running status and transparent realtime bytes.
//
//   Ports:
//     clk          in   1  system clock
//     reset        in   1  synchronous, active-high reset
//     midi         slave   midi_byte / midi_valid byte stream
//     channel_sel  in   4  MIDI channel to decode (0..15)
//     note_on      out  1  voice gate
//     note         out  7  current/last note number
//     vel          out  4  current velocity
//     pb           out  9  pitch bend, 256 = centre
//     note_repeat  out  1  one-cycle pulse: note-on for the sounding note
//
//   Build option:
//     MIDI_OMNI_EN  when defined, channel_sel is ignored and every channel
//                   drives the single shared voice state.
// ---------------------------------------------------------------------------
module midi_mono_decoder #(
    parameter logic [3:0] VEL_MIN    = 4'd1,
    parameter logic [8:0] PB_RESET   = 9'd256,
    parameter logic [6:0] CC_ALL_OFF = 7'd123
) (
    input  logic                       clk,
    input  logic                       reset,
    midi_mono_decoder_if.slave         midi,
    input  logic [3:0]                 channel_sel,
    output logic                       note_on,
    output logic [6:0]                 note,
    output logic [3:0]                 vel,
    output logic [8:0]                 pb,
    output logic                       note_repeat
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_D1    = 3'd1;
    localparam logic [2:0] ST_D2    = 3'd2;
    localparam logic [2:0] ST_SKIP  = 3'd3;
    localparam logic [2:0] ST_SYSEX = 3'd4;

    logic [2:0] state;
    logic [3:0] status_hi;
    logic       matched;
    logic       skip_more;
    logic [6:0] data1;

    logic [7:0] byte_in;
    logic       is_status;
    logic       is_realtime;
    logic       chan_match;
    logic       new_one_byte;
    logic       run_one_byte;
    logic       same_note;

    assign byte_in      = midi.midi_byte;
    assign is_status    = byte_in[7];
    assign is_realtime  = (byte_in[7:3] == 5'b11111);
    assign new_one_byte = (byte_in[7:4] == 4'hC) || (byte_in[7:4] == 4'hD);
    assign run_one_byte = (status_hi == 4'hC) || (status_hi == 4'hD);
    assign same_note    = note_on && (data1 == note);

`ifdef MIDI_OMNI_EN
    assign chan_match = 1'b1;
`else
    assign chan_match = (byte_in[3:0] == channel_sel);
`endif

    // 7-bit velocity to 4 bits, with a floor so soft notes never read as 0.
    function automatic logic [3:0] scale_vel(input logic [6:0] v);
        return (v[6:3] < VEL_MIN) ? VEL_MIN : v[6:3];
    endfunction

    // Status bytes always restart parsing; data bytes advance the message.
    // A channel mismatch is tracked by 'matched' so that running-status
    // repeats of a foreign channel keep being consumed without effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            status_hi   <= 4'h0;
            matched     <= 1'b0;
            skip_more   <= 1'b0;
            data1       <= 7'd0;
            note_on     <= 1'b0;
            note        <= 7'd0;
            vel         <= 4'd0;
            pb          <= PB_RESET;
            note_repeat <= 1'b0;
        end else begin
            note_repeat <= 1'b0;
            if (midi.midi_valid && !is_realtime) begin
                if (is_status) begin
                    if (byte_in == 8'hF0) begin
                        state <= ST_SYSEX;
                    end else if (byte_in[7:4] == 4'hF) begin
                        state <= ST_IDLE;
                    end else begin
                        status_hi <= byte_in[7:4];
                        matched   <= chan_match;
                        if (chan_match) begin
                            state <= ST_D1;
                        end else begin
                            state     <= ST_SKIP;
                            skip_more <= !new_one_byte;
                        end
                    end
                end else begin
                    case (state)
                        ST_D1: begin
                            if (!matched) begin
                                // foreign running status: first byte of a
                                // two-byte message leaves one more to skip
                                if (!run_one_byte) begin
                                    state     <= ST_SKIP;
                                    skip_more <= 1'b0;
                                end
                            end else if (!run_one_byte) begin
                                data1 <= byte_in[6:0];
                                state <= ST_D2;
                            end
                        end
                        ST_D2: begin
                            state <= ST_D1;
                            case (status_hi)
                                4'h9: begin
                                    if (byte_in[6:0] != 7'd0) begin
                                        note    <= data1;
                                        vel     <= scale_vel(byte_in[6:0]);
                                        note_on <= 1'b1;
                                        if (same_note) begin
                                            note_repeat <= 1'b1;
                                        end
                                    end else if (same_note) begin
                                        note_on <= 1'b0;
                                    end
                                end
                                4'h8: begin
                                    if (same_note) begin
                                        note_on <= 1'b0;
                                    end
                                end
                                4'hE: begin
                                    // top 9 bits of the 14-bit bend value
                                    pb <= {byte_in[6:0], data1[6:5]};
                                end
                                4'hB: begin
                                    if (data1 == CC_ALL_OFF) begin
                                        note_on <= 1'b0;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                        ST_SKIP: begin
                            if (skip_more) begin
                                skip_more <= 1'b0;
                            end else begin
                                state <= ST_D1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_mono_decoder.sv
// ---------------------------------------------------------------------------
// tb_midi_mono_decoder
//   Directed byte sequences drive midi_mono_decoder. A byte-level MIDI model
//   (running status, pending data queue, sysex flag) predicts the voice
//   state; a compare process checks every cycle, and literal checks pin the
//   model at key points.
// ---------------------------------------------------------------------------
module tb_midi_mono_decoder;

    localparam int VEL_MIN_M    = 1;
    localparam int PB_RESET_M   = 256;
    localparam int CC_ALL_OFF_M = 123;

`ifdef MIDI_OMNI_EN
    localparam bit OMNI = 1'b1;
`else
    localparam bit OMNI = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] channel_sel;
    logic       note_on;
    logic [6:0] note;
    logic [3:0] vel;
    logic [8:0] pb;
    logic       note_repeat;

    midi_mono_decoder_if bus ();

    midi_mono_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .midi        (bus),
        .channel_sel (channel_sel),
        .note_on     (note_on),
        .note        (note),
        .vel         (vel),
        .pb          (pb),
        .note_repeat (note_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_on, m_note, m_vel, m_pb, m_rep;
    int run_status;
    bit run_ok;
    int data_q[$];
    bit started = 1'b0;

    function automatic int msg_len(input int st);
        int k;
        k = st / 16;
        return (k == 12 || k == 13) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_on = 0; m_note = 0; m_vel = 0; m_pb = PB_RESET_M; m_rep = 0;
        run_status = -1;
        run_ok = 1'b0;
        data_q.delete();
    endtask

    task automatic model_exec();
        int kind, d0, d1, v;
        kind = run_status / 16;
        d0 = data_q[0];
        d1 = (data_q.size() > 1) ? data_q[1] : 0;
        if (kind == 9 && d1 > 0) begin
            if (m_on == 1 && d0 == m_note) m_rep = 1;
            v = d1 / 8;
            m_vel  = (v < VEL_MIN_M) ? VEL_MIN_M : v;
            m_note = d0;
            m_on   = 1;
        end else if (kind == 9 || kind == 8) begin
            if (m_on == 1 && d0 == m_note) m_on = 0;
        end else if (kind == 14) begin
            m_pb = (d1 * 128 + d0) / 32;
        end else if (kind == 11) begin
            if (d0 == CC_ALL_OFF_M) m_on = 0;
        end
    endtask

    task automatic model_byte(input int b);
        if (b >= 'hF8) begin
        end else if (b >= 'hF0) begin
            run_status = -1;
            data_q.delete();
        end else if (b >= 'h80) begin
            run_status = b;
            run_ok = OMNI || ((b % 16) == int'(channel_sel));
            data_q.delete();
        end else if (run_status >= 0) begin
            data_q.push_back(b);
            if (data_q.size() == msg_len(run_status)) begin
                if (run_ok) model_exec();
                data_q.delete();
            end
        end
    endtask

    // model advances on the same edge the DUT samples its inputs
    initial begin
        forever begin
            @(posedge clk);
            m_rep = 0;
            if (reset) begin
                model_reset();
                started = 1'b1;
            end else if (bus.midi_valid) begin
                model_byte(int'(bus.midi_byte));
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                total++;
                if (note_on !== 1'(m_on) || note !== 7'(m_note) || vel !== 4'(m_vel) ||
                    pb !== 9'(m_pb) || note_repeat !== 1'(m_rep)) begin
                    bad++;
                    $display("[TB] FAIL model_cmp t=%0t got on=%0d note=%0h vel=%0d pb=%0d rep=%0d want on=%0d note=%0h vel=%0d pb=%0d rep=%0d",
                             $time, note_on, note, vel, pb, note_repeat, m_on, m_note, m_vel, m_pb, m_rep);
                end
            end
        end
    end

    // one byte per cycle; consecutive calls keep midi_valid high back-to-back
    task automatic applyStimulus(input logic [7:0] b);
        bus.midi_byte  = b;
        bus.midi_valid = 1'b1;
        @(negedge clk);
        bus.midi_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int e_on, input int e_note,
                               input int e_vel, input int e_pb, input int e_rep);
        total++;
        if (note_on !== 1'(e_on) || note !== 7'(e_note) || vel !== 4'(e_vel) ||
            pb !== 9'(e_pb) || note_repeat !== 1'(e_rep)) begin
            bad++;
            $display("[TB] FAIL %s got on=%0d note=%0h vel=%0d pb=%0d rep=%0d want on=%0d note=%0h vel=%0d pb=%0d rep=%0d",
                     name, note_on, note, vel, pb, note_repeat, e_on, e_note, e_vel, e_pb, e_rep);
        end
    endtask

    initial begin
        reset          = 1'b1;
        channel_sel    = 4'd0;
        bus.midi_byte  = 8'h00;
        bus.midi_valid = 1'b0;
        idleCycles(2);
        reset = 1'b0;
        checkOutput("reset_values", 0, 'h00, 0, 256, 0);

        // basic note-on
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
        checkOutput("note_on_basic", 1, 'h3C, 12, 256, 0);

        // running status legato, then mismatched note-off is ignored
        applyStimulus(8'h40); applyStimulus(8'h50);
        checkOutput("running_legato", 1, 'h40, 10, 256, 0);
        applyStimulus(8'h3C); applyStimulus(8'h00);
        checkOutput("off_mismatch", 1, 'h40, 10, 256, 0);

        // repeat pulse, then note-off
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
        checkOutput("legato_back", 1, 'h3C, 12, 256, 0);
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h20);
        checkOutput("repeat_pulse", 1, 'h3C, 4, 256, 1);
        idleCycles(1);
        checkOutput("repeat_drop", 1, 'h3C, 4, 256, 0);
        applyStimulus(8'h80); applyStimulus(8'h3C); applyStimulus(8'h00);
        checkOutput("note_off", 0, 'h3C, 4, 256, 0);

        // pitch bend range, with realtime bytes interleaved
        applyStimulus(8'hE0); applyStimulus(8'h00); applyStimulus(8'h40);
        checkOutput("pb_centre", 0, 'h3C, 4, 256, 0);
        applyStimulus(8'hE0); applyStimulus(8'h7F); applyStimulus(8'h7F);
        checkOutput("pb_max", 0, 'h3C, 4, 511, 0);
        applyStimulus(8'hE0); applyStimulus(8'h00); applyStimulus(8'h00);
        checkOutput("pb_min", 0, 'h3C, 4, 0, 0);
        applyStimulus(8'hE0); applyStimulus(8'hF8); applyStimulus(8'h7F);
        applyStimulus(8'hF8); applyStimulus(8'h7F);
        checkOutput("pb_max_rt", 0, 'h3C, 4, 511, 0);
        applyStimulus(8'hE0); applyStimulus(8'h00); applyStimulus(8'hFE); applyStimulus(8'h40);
        checkOutput("pb_centre_rt", 0, 'h3C, 4, 256, 0);

        // foreign channel, including running-status repeats
        applyStimulus(8'h91); applyStimulus(8'h3C); applyStimulus(8'h64);
        if (OMNI) checkOutput("chan1_omni", 1, 'h3C, 12, 256, 0);
        else      checkOutput("chan1_skip", 0, 'h3C, 4, 256, 0);
        applyStimulus(8'h45); applyStimulus(8'h7F);
        if (OMNI) checkOutput("chan1_run_omni", 1, 'h45, 15, 256, 0);
        else      checkOutput("chan1_run_skip", 0, 'h3C, 4, 256, 0);
        applyStimulus(8'hC1); applyStimulus(8'h05); applyStimulus(8'h06);

        // other selected channel, and velocity floor after program change
        channel_sel = 4'd5;
        applyStimulus(8'h95); applyStimulus(8'h3A); applyStimulus(8'h7F);
        checkOutput("chan5_sel", 1, 'h3A, 15, 256, 0);
        channel_sel = 4'd0;
        applyStimulus(8'hC0); applyStimulus(8'h05);
        applyStimulus(8'hA0); applyStimulus(8'h3A); applyStimulus(8'h10);
        applyStimulus(8'h90); applyStimulus(8'h45); applyStimulus(8'h07);
        checkOutput("vel_floor", 1, 'h45, 1, 256, 0);

        // sysex swallows data until a status byte
        applyStimulus(8'hF0); applyStimulus(8'h80); applyStimulus(8'h45); applyStimulus(8'h00);
        checkOutput("sysex_abort_off", 0, 'h45, 1, 256, 0);
        applyStimulus(8'hF0); applyStimulus(8'h3C); applyStimulus(8'h64); applyStimulus(8'hF7);
        applyStimulus(8'h3C); applyStimulus(8'h64);
        checkOutput("sysex_ignored", 0, 'h45, 1, 256, 0);

        // partial message aborted by CC all-notes-off
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
        applyStimulus(8'h90); applyStimulus(8'h3C);
        applyStimulus(8'hB0); applyStimulus(8'h7B); applyStimulus(8'h00);
        checkOutput("cc_all_off", 0, 'h3C, 12, 256, 0);

        // reset in mid-message
        applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
        applyStimulus(8'hE0); applyStimulus(8'h7F); applyStimulus(8'h7F);
        applyStimulus(8'h90);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        checkOutput("mid_reset", 0, 'h00, 0, 256, 0);
        applyStimulus(8'h3C); applyStimulus(8'h64);
        checkOutput("post_reset_drop", 0, 'h00, 0, 256, 0);

        idleCycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
